// File: rtl/axi3_rd_arbiter_pkg.sv
// Shared AXI3 read-channel types and the arbiter FSM state encoding.
package axi3_rd_arbiter_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 32;
    localparam int unsigned AXI_LEN_W  = 4;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} axi_arb_state_t;

    // Master-driven AR channel plus the R-channel ready.
    typedef struct packed {
        logic                  arvalid;
        logic [AXI_ADDR_W-1:0] araddr;
        logic [AXI_LEN_W-1:0]  arlen;
        logic [2:0]            arsize;
        logic [1:0]            arburst;
        logic [1:0]            arlock;
        logic [3:0]            arcache;
        logic [2:0]            arprot;
        logic                  rready;
    } axi3_rd_req_t;

    // Slave-driven AR ready plus the R channel payload.
    typedef struct packed {
        logic                  arready;
        logic                  rvalid;
        logic [AXI_DATA_W-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rlast;
    } axi3_rd_resp_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after 'last', wrapping.
module rr_pick #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int unsigned LW = $clog2(N);

    int unsigned cand;

    // Scan N candidates starting one past the previous winner; first hit wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last) + k) % N;
            if (!valid && req[LW'(cand)]) begin
                valid = 1'b1;
                idx   = LW'(cand);
            end
        end
    end

endmodule

// File: rtl/axi3_rd_arbiter.sv
// Round-robin arbiter sharing one AXI3 read port; grant held from AR through rlast.
module axi3_rd_arbiter
    import axi3_rd_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned BUS_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  axi3_rd_req_t  [N_REQ-1:0]            s_req,
    input  logic          [N_REQ-1:0][BUS_WIDTH-1:0] s_arid,
    output axi3_rd_resp_t [N_REQ-1:0]            s_resp,
    output logic          [N_REQ-1:0][BUS_WIDTH-1:0] s_rid,
    output axi3_rd_req_t                         m_req,
    output logic          [BUS_WIDTH-1:0]        m_arid,
    input  axi3_rd_resp_t                        m_resp,
    input  logic          [BUS_WIDTH-1:0]        m_rid
);

    localparam int unsigned GW = $clog2(N_REQ);

    axi_arb_state_t  state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;

    logic [N_REQ-1:0] arvalid_vec;
    logic             pick_valid;
    logic [GW-1:0]    pick_idx;

    // Gather per-requester arvalid for the selector.
    always_comb begin
        arvalid_vec = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            arvalid_vec[i] = s_req[i].arvalid;
        end
    end

    rr_pick #(.N(N_REQ)) u_rr_pick (
        .req   (arvalid_vec),
        .last  (last_grant_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State, grant and round-robin pointer; last_grant resets so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state and mux/demux; only the granted requester ever sees response traffic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        m_req        = '0;
        m_arid       = '0;
        s_resp       = '0;
        s_rid        = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                // Forward as-is even if arvalid drops; no re-arbitration mid-address.
                m_req                   = s_req[grant_q];
                m_req.rready            = 1'b0;
                m_arid                  = s_arid[grant_q];
                s_resp[grant_q].arready = m_resp.arready;
                if (s_req[grant_q].arvalid && m_resp.arready) begin
                    state_d = ARB_DATA;
                end
            end
            ARB_DATA: begin
                m_req.rready           = s_req[grant_q].rready;
                s_resp[grant_q].rvalid = m_resp.rvalid;
                s_resp[grant_q].rdata  = m_resp.rdata;
                s_resp[grant_q].rresp  = m_resp.rresp;
                s_resp[grant_q].rlast  = m_resp.rlast;
                s_rid[grant_q]         = m_rid;
                if (m_resp.rvalid && s_req[grant_q].rready && m_resp.rlast) begin
                    last_grant_d = grant_q;
                    state_d      = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: doc/axi3_rd_arbiter.md
# axi3_rd_arbiter

Shares one AXI3 read master port between `N_REQ` cache-side requesters (I$ refill, D$ refill, uncached loads). Arbitration is round-robin, and a grant is locked for one whole transaction, from the AR handshake through the `rlast` beat. The block sits between the cache miss engines and the top-level AXI3 read port, and uses the shared `axi3_rd_req_t` and `axi3_rd_resp_t` structs. At most one transaction is outstanding at a time.

## Interface
- `N_REQ`, 2, number of requesters, from 2 to 8.
- `BUS_WIDTH`, 4, width of the AXI ID fields.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `s_req`  in  `[N_REQ-1:0]` × `axi3_rd_req_t`  per-requester AR and R-ready signals.
- `s_arid`  in  `[N_REQ-1:0]` × `BUS_WIDTH`  per-requester ARID.
- `s_resp`  out  `[N_REQ-1:0]` × `axi3_rd_resp_t`  per-requester AR-ready and R channel.
- `s_rid`  out  `[N_REQ-1:0]` × `BUS_WIDTH`  per-requester RID.
- `m_req`  out  `axi3_rd_req_t`  request to the shared bus.
- `m_arid`  out  `BUS_WIDTH`  ARID forwarded from the granted requester.
- `m_resp`  in  `axi3_rd_resp_t`  response from the shared bus.
- `m_rid`  in  `BUS_WIDTH`  RID from the shared bus.

## Operation
- FSM states: `IDLE`, `ADDR`, `DATA`.
- Registers: `state`, `grant` (`$clog2(N_REQ)` bits), `last_grant`.
- `IDLE`:
  - `m_req` and `m_arid` are all zero.
  - Every `s_resp` and `s_rid` is zero.
  - If any `s_req[i].arvalid` is set, register `grant` as the first requester with `arvalid` set, searching from `last_grant+1` upward with wrap modulo `N_REQ`. Then go to `ADDR`.
- `ADDR`:
  - All AR fields of `s_req[grant]` and `s_arid[grant]` are forwarded to `m_req` and `m_arid`.
  - `s_resp[grant].arready` equals `m_resp.arready`.
  - `m_req.rready` is 0.
  - On `arvalid && arready`, go to `DATA`.
  - A requester that deasserts `arvalid` while waiting is violating AXI. The FSM stays in `ADDR` and forwards the deasserted value; it does not re-arbitrate.
- `DATA`:
  - `m_req.arvalid` is 0.
  - `m_req.rready` equals `s_req[grant].rready`.
  - `rdata`, `rresp`, `rlast`, `rvalid` and `rid` are routed to `s_resp[grant]` and `s_rid[grant]` only.
  - On `rvalid && rready && rlast`: set `last_grant <= grant` and go to `IDLE`.
- Non-granted requesters always see `arready`, `rvalid`, `rlast`, `rdata`, `rresp` and `rid` as 0.
- Outputs are combinational from the registered state and grant plus the inputs being forwarded. No arbitration decision depends combinationally on `m_resp`.
- `rresp` errors (SLVERR, DECERR) are forwarded unchanged. The arbiter does not inspect them.

## Timing
- Reset (async assertion, sync release):
  - `state=IDLE`, `grant=0`, `last_grant=N_REQ-1`, so requester 0 wins first.
  - All outputs are 0 while `rst` is high.
- Latency: `s_req[i].arvalid` rising in cycle t gives `m_req.arvalid` in cycle t+1. `m_resp.arready` reaches `s_resp[grant].arready` in the same cycle.
- R beats pass through with zero added latency. Burst length is unlimited and is ended only by `rlast`.
- A transaction ends with `rlast` accepted in cycle t. The next transaction's `m_req.arvalid` is earliest in cycle t+2: one cycle in `IDLE` for arbitration.
- Simultaneous requests: round-robin order starting after `last_grant`. No requester waits more than `N_REQ-1` transactions.
- `rvalid` while in `IDLE` or `ADDR` is a slave protocol error. It is not forwarded, and `m_req.rready` stays 0.
- Reset asserted mid-burst: the transaction is abandoned. The upstream AXI slave must be reset by the same `rst`.

## Structure
- Add to the shared package:
  - `typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} axi_arb_state_t`.
  - The reuse of `axi3_rd_req_t` and `axi3_rd_resp_t`.
- Sub-module `rr_pick #(N)`: combinational round-robin selector.
  - Inputs: `req[N-1:0]`, `last[$clog2(N)-1:0]`.
  - Outputs: `valid`, `idx`.
- The FSM and the mux/demux logic live in `axi3_rd_arbiter`.

## Test plan
- Single request: requester 0 issues `araddr=0x1FC0_0000`, `arlen=3`. Expect `m_req.arvalid` one cycle later. Four beats `0xA0..0xA3` reach `s_resp[0]` only, and `s_resp[1].rvalid` stays 0.
- Simultaneous request after reset: both requesters assert `arvalid` together. Requester 0 is granted first; after its `rlast`, requester 1 is granted. `m_req.arvalid` rises again 2 cycles after the `rlast` handshake.
- Fairness: both requesters hold `arvalid` continuously for 6 transactions. Grants alternate 0,1,0,1,0,1.
- Backpressure: `m_resp.arready` is held low for 5 cycles. The grant and AR fields stay stable. Mid-burst, `s_req[grant].rready` is held low for 3 cycles and `m_req.rready` mirrors it, with no beat lost.
- Reset mid-burst: `rst` asserted on beat 2 of 4. All outputs go to 0 immediately. After release, requester 0 has priority again.
- Stray response: `m_resp.rvalid=1` while in `IDLE`. No `s_resp` sees `rvalid`, and `m_req.rready` stays 0.
